// File: rtl/anita4_scalers.sv
// anita4_scalers
//   Trigger-rate scaler bank. Counts rising edges on NUM_CHAN trigger lines
//   over each PPS interval, with saturating per-channel counters and an
//   overflow flag. It also accumulates gated deadtime and keeps a PPS
//   snapshot sequence number. Every held value is read through one
//   registered readout mux.
//
// Ports
//   clk33_i      : 33 MHz system clock, rising edge
//   rst_n_i      : synchronous active-low reset
//   trig_i       : asynchronous trigger lines (level)
//   gate_i       : deadtime gate, high suppresses counting
//   pps_i        : PPS level, a rising edge closes the interval
//   sec_i        : seconds count, passed through to the readout
//   c3po_i       : 250 MHz clock count, passed through to the readout
//   scal_addr_i  : readout address
//   scal_dat_o   : registered readout data (1-cycle latency)
//
// Readout map
//   addr <  NUM_CHAN   : {hold_ovf, zero pad, hold[CNT_WIDTH-1:0]}
//   addr == NUM_CHAN   : held deadtime
//   addr == NUM_CHAN+1 : c3po_i
//   addr == NUM_CHAN+2 : {sec_i, seq}
//   other addresses    : 0
module anita4_scalers #(
  parameter int unsigned NUM_CHAN   = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                  clk33_i,
  input  logic                  rst_n_i,
  input  logic [NUM_CHAN-1:0]   trig_i,
  input  logic                  gate_i,
  input  logic                  pps_i,
  input  logic [15:0]           sec_i,
  input  logic [31:0]           c3po_i,
  input  logic [ADDR_WIDTH-1:0] scal_addr_i,
  output logic [31:0]           scal_dat_o
);

  // Input sampling stages
  logic [NUM_CHAN-1:0]  r1_q, r2_q;
  logic                 p1_q, p2_q;
  logic                 g1_q;

  // Counting state and PPS snapshots
  logic [CNT_WIDTH-1:0] cnt_q  [NUM_CHAN];
  logic [CNT_WIDTH-1:0] cnt_d  [NUM_CHAN];
  logic [CNT_WIDTH-1:0] hold_q [NUM_CHAN];
  logic [CNT_WIDTH-1:0] hold_d [NUM_CHAN];
  logic [NUM_CHAN-1:0]  ovf_q, ovf_d;
  logic [NUM_CHAN-1:0]  hold_ovf_q, hold_ovf_d;
  logic [31:0]          dead_q, dead_d;
  logic [31:0]          dead_hold_q, dead_hold_d;
  logic [15:0]          seq_q, seq_d;
  logic [31:0]          dat_q, dat_d;

  logic [NUM_CHAN-1:0]  trig_edge;
  logic [NUM_CHAN-1:0]  count_en;
  logic                 pps_edge;
  logic [31:0]          addr_ext;

  assign trig_edge  = r1_q & ~r2_q;
  // A gated edge is dropped outright: it is never carried into a later cycle.
  assign count_en   = trig_edge & ~{NUM_CHAN{g1_q}};
  assign pps_edge   = p1_q & ~p2_q;
  assign addr_ext   = 32'(scal_addr_i);
  assign scal_dat_o = dat_q;

  // Per-channel counters. An edge that coincides with the PPS edge seeds the
  // new interval instead of being added to the value being held.
  always_comb begin
    ovf_d      = ovf_q;
    hold_ovf_d = hold_ovf_q;
    for (int unsigned j = 0; j < NUM_CHAN; j++) begin
      cnt_d[j]  = cnt_q[j];
      hold_d[j] = hold_q[j];
      if (pps_edge) begin
        hold_d[j]     = cnt_q[j];
        hold_ovf_d[j] = ovf_q[j];
        cnt_d[j]      = count_en[j] ? CNT_WIDTH'(1) : '0;
        ovf_d[j]      = 1'b0;
      end else if (count_en[j]) begin
        if (&cnt_q[j]) begin
          ovf_d[j] = 1'b1;
        end else begin
          cnt_d[j] = cnt_q[j] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Deadtime accumulator and snapshot sequence number
  always_comb begin
    dead_d      = dead_q;
    dead_hold_d = dead_hold_q;
    seq_d       = seq_q;
    if (pps_edge) begin
      dead_hold_d = dead_q;
      dead_d      = {31'b0, g1_q};
      seq_d       = seq_q + 16'd1;
    end else if (g1_q && (dead_q != '1)) begin
      dead_d = dead_q + 32'd1;
    end
  end

  // Readout mux. Channel words put the count in the low bits and the
  // overflow flag in bit 31, so a plain slice assignment avoids a
  // zero-width pad when CNT_WIDTH is 31.
  always_comb begin
    dat_d = '0;
    for (int unsigned j = 0; j < NUM_CHAN; j++) begin
      if (addr_ext == j) begin
        dat_d[CNT_WIDTH-1:0] = hold_q[j];
        dat_d[31]            = hold_ovf_q[j];
      end
    end
    if (addr_ext == NUM_CHAN) begin
      dat_d = dead_hold_q;
    end else if (addr_ext == NUM_CHAN + 1) begin
      dat_d = c3po_i;
    end else if (addr_ext == NUM_CHAN + 2) begin
      dat_d = {sec_i, seq_q};
    end
  end

  always_ff @(posedge clk33_i) begin
    if (!rst_n_i) begin
      r1_q        <= '0;
      r2_q        <= '0;
      p1_q        <= 1'b0;
      p2_q        <= 1'b0;
      g1_q        <= 1'b0;
      ovf_q       <= '0;
      hold_ovf_q  <= '0;
      dead_q      <= '0;
      dead_hold_q <= '0;
      seq_q       <= '0;
      dat_q       <= '0;
      for (int unsigned j = 0; j < NUM_CHAN; j++) begin
        cnt_q[j]  <= '0;
        hold_q[j] <= '0;
      end
    end else begin
      r1_q        <= trig_i;
      r2_q        <= r1_q;
      p1_q        <= pps_i;
      p2_q        <= p1_q;
      g1_q        <= gate_i;
      ovf_q       <= ovf_d;
      hold_ovf_q  <= hold_ovf_d;
      dead_q      <= dead_d;
      dead_hold_q <= dead_hold_d;
      seq_q       <= seq_d;
      dat_q       <= dat_d;
      for (int unsigned j = 0; j < NUM_CHAN; j++) begin
        cnt_q[j]  <= cnt_d[j];
        hold_q[j] <= hold_d[j];
      end
    end
  end

endmodule

// File: tb/tb_anita4_scalers.sv
// Testbench for anita4_scalers: directed scenarios plus randomized traffic,
// every cycle's readout compared with a behavioural reference model.
module tb_anita4_scalers;

  localparam int unsigned NCH  = 8;
  localparam int unsigned CW   = 4;
  localparam int unsigned AW   = 4;
  localparam int unsigned MAXC = (1 << CW) - 1;

  logic           clk;
  logic           rst_n;
  logic [NCH-1:0] trig;
  logic           gate;
  logic           pps;
  logic [15:0]    sec;
  logic [31:0]    c3po;
  logic [AW-1:0]  addr;
  logic [31:0]    dout;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  // Reference model: raw edge totals per interval, clipped only when held
  int unsigned     raw [NCH];
  int unsigned     hv  [NCH];
  logic            ho  [NCH];
  longint unsigned dead_raw;
  logic [31:0]     dead_hold_m;
  int unsigned     seq_m;
  logic [NCH-1:0]  t1, t2;    // trigger samples from the previous two edges
  logic            q1, q2, gq;

  anita4_scalers #(
    .NUM_CHAN  (NCH),
    .CNT_WIDTH (CW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk33_i    (clk),
    .rst_n_i    (rst_n),
    .trig_i     (trig),
    .gate_i     (gate),
    .pps_i      (pps),
    .sec_i      (sec),
    .c3po_i     (c3po),
    .scal_addr_i(addr),
    .scal_dat_o (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read();
    logic [31:0] w;
    int unsigned a;
    w = '0;
    a = 32'(addr);
    if (a < NCH) begin
      w     = hv[a];
      w[31] = ho[a];
    end else if (a == NCH) begin
      w = dead_hold_m;
    end else if (a == NCH + 1) begin
      w = c3po;
    end else if (a == NCH + 2) begin
      w = {sec, seq_m[15:0]};
    end
    return w;
  endfunction

  function automatic void model_step();
    logic ppse;
    logic ev;
    if (!rst_n) begin
      for (int j = 0; j < NCH; j++) begin
        raw[j] = 0;
        hv[j]  = 0;
        ho[j]  = 1'b0;
      end
      dead_raw    = 0;
      dead_hold_m = '0;
      seq_m       = 0;
      t1 = '0; t2 = '0; q1 = 1'b0; q2 = 1'b0; gq = 1'b0;
    end else begin
      ppse = q1 && !q2;
      for (int j = 0; j < NCH; j++) begin
        ev = t1[j] && !t2[j] && !gq;
        if (ppse) begin
          hv[j]  = (raw[j] > MAXC) ? MAXC : raw[j];
          ho[j]  = (raw[j] > MAXC);
          raw[j] = ev ? 1 : 0;
        end else if (ev) begin
          raw[j] = raw[j] + 1;
        end
      end
      if (ppse) begin
        dead_hold_m = (dead_raw > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : dead_raw[31:0];
        dead_raw    = {63'b0, gq};
        seq_m       = (seq_m + 1) % 65536;
      end else begin
        dead_raw = dead_raw + {63'b0, gq};
      end
      t2 = t1; t1 = trig;
      q2 = q1; q1 = pps;
      gq = gate;
    end
  endfunction

  // One clock: expected readout comes from model state before the edge.
  task automatic cycle();
    logic [31:0] exp;
    c3po = $urandom;
    sec  = 16'($urandom);
    @(posedge clk);
    exp = rst_n ? model_read() : 32'h0;
    model_step();
    #1;
    chk("rd", dout, exp);
  endtask

  task automatic pulse(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      trig[ch] = 1'b1;
      cycle();
      trig[ch] = 1'b0;
      cycle();
    end
  endtask

  task automatic pps_pulse();
    pps = 1'b1;
    cycle();
    pps = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic rd(input int a);
    addr = AW'(a);
    cycle();
  endtask

  initial begin
    rst_n = 1'b0; trig = '0; gate = 1'b0; pps = 1'b0; addr = '0;
    sec = '0; c3po = '0;
    repeat (4) cycle();
    rst_n = 1'b1;
    cycle();

    // Everything reads zero after reset except the passthroughs
    for (int a = 0; a < (1 << AW); a++) begin
      rd(a);
      if (a == NCH + 1)      chk("rst_c3po", dout, c3po);
      else if (a == NCH + 2) chk("rst_sec", dout, {sec, 16'h0});
      else                   chk("rst_zero", dout, 32'h0);
    end

    // Basic counting
    pulse(3, 5);
    pulse(0, 2);
    pps_pulse();
    rd(3);       chk("ch3_cnt", dout, 32'h5);
    rd(0);       chk("ch0_cnt", dout, 32'h2);
    rd(NCH + 2); chk("seq1", {16'h0, dout[15:0]}, 32'h1);

    // Saturation and overflow flag, then a clean interval
    pulse(1, 20);
    pps_pulse();
    rd(1); chk("ch1_sat", dout, 32'h8000_000F);
    pulse(1, 3);
    pps_pulse();
    rd(1); chk("ch1_after", dout, 32'h3);

    // Gate discards edges and accumulates deadtime
    pps_pulse();
    gate = 1'b1;
    pulse(2, 10);
    repeat (80) cycle();
    gate = 1'b0;
    pulse(2, 4);
    pps_pulse();
    rd(2);   chk("ch2_gated", dout, 32'h4);
    rd(NCH); chk("dead", dout, 32'd100);

    // Edge coincident with the PPS edge belongs to the new interval
    pps_pulse();
    trig[5] = 1'b1; pps = 1'b1;
    cycle();
    trig[5] = 1'b0; pps = 1'b0;
    repeat (4) cycle();
    rd(5); chk("ch5_excl", dout, 32'h0);
    pulse(5, 2);
    pps_pulse();
    rd(5); chk("ch5_next", dout, 32'h3);

    // Reset mid-interval discards it
    pulse(0, 7);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    pulse(0, 2);
    pps_pulse();
    rd(0);       chk("ch0_post_rst", dout, 32'h2);
    rd(NCH + 2); chk("seq_post_rst", {16'h0, dout[15:0]}, 32'h1);

    // Randomized traffic checked against the model every cycle
    for (int i = 0; i < 4000; i++) begin
      trig  = NCH'($urandom);
      gate  = ($urandom_range(0, 3) == 0);
      pps   = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 399) != 0);
      addr  = AW'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/anita4_scalers.md
# anita4_scalers

Parametrised trigger-rate scaler bank for the TURF, successor to the fixed 32×8-bit L3 scaler block. It counts rising edges on `NUM_CHAN` trigger lines per PPS interval with configurable counter width and saturation/overflow flagging. It also accumulates gated deadtime and holds a PPS snapshot sequence number. All values are presented on a registered readout mux for the register-interface scaler space.

## Interface
Parameters:
- `NUM_CHAN`, 32: number of trigger channels (1–64).
- `CNT_WIDTH`, 16: per-channel counter width (1–31).
- `ADDR_WIDTH`, 7: readout address width; `NUM_CHAN+3 <= 2**ADDR_WIDTH`.

Ports:
- `clk33_i`, input, 1: 33 MHz system clock; all logic on its rising edge.
- `rst_n_i`, input, 1: synchronous, active-low reset.
- `trig_i`, input, `NUM_CHAN`: asynchronous trigger lines (level; each pulse high ≥1 clk, low ≥1 clk).
- `gate_i`, input, 1: deadtime gate; high suppresses counting.
- `pps_i`, input, 1: PPS level; rising edge ends the interval.
- `sec_i`, input, 16: current seconds count (passed through).
- `c3po_i`, input, 32: 250 MHz clock-count value (passed through).
- `scal_addr_i`, input, `ADDR_WIDTH`: readout address.
- `scal_dat_o`, output, 32: registered readout data.

## Operation
- Input registers, one stage each from `clk33_i`:
  - `r1 <= trig_i`, then `r2 <= r1`.
  - `p1 <= pps_i`, then `p2 <= p1`.
  - `g1 <= gate_i`.
- Detected events:
  - Channel edge `e[j] = r1[j] & ~r2[j]`.
  - `pps_edge = p1 & ~p2`.
- Per-channel counter `cnt[j]` (`CNT_WIDTH` bits) and overflow flag `ovf[j]`:
  - If `pps_edge`:
    - `hold[j] <= cnt[j]` and `hold_ovf[j] <= ovf[j]`.
    - `cnt[j] <= (e[j] & ~g1) ? 1 : 0`.
    - `ovf[j] <= 0`.
    - An edge coincident with the PPS edge belongs to the new interval.
  - Else if `e[j] & ~g1`:
    - If `cnt[j]` is all-ones, `cnt[j]` holds and `ovf[j] <= 1` (saturate, no wrap).
    - Otherwise `cnt[j] <= cnt[j]+1`.
  - Edges while `g1` is high are discarded, not deferred.
- Deadtime counter `dead` (32 bits):
  - Increments each cycle `g1` is high; saturates at `32'hFFFFFFFF`.
  - On `pps_edge`: `dead_hold <= dead` and `dead <= g1 ? 1 : 0`.
- Snapshot sequence `seq` (16 bits): increments on every `pps_edge`, wraps `16'hFFFF→0`.
- Readout map, registered (`scal_dat_o <= mux(scal_addr_i)` every cycle):
  - `addr < NUM_CHAN`: `{hold_ovf[addr], zero pad, hold[addr]}`, with the count in the low `CNT_WIDTH` bits and the flag in bit 31.
  - `addr == NUM_CHAN`: `dead_hold`.
  - `addr == NUM_CHAN+1`: `c3po_i`.
  - `addr == NUM_CHAN+2`: `{sec_i, seq}`.
  - Any other address: `32'h0`.
- Reset (`rst_n_i` low at a clock edge):
  - Clears all input registers, `cnt`, `ovf`, `hold`, `hold_ovf`, `dead`, `dead_hold`, `seq`, and `scal_dat_o` to 0.
  - Reset dominates `pps_edge` and trigger edges in the same cycle.
  - Reset mid-interval discards that interval; the first PPS after release produces a partial count.
  - Because `p2=0` after reset, a `pps_i` already high at release yields a `pps_edge` 1 cycle later (`p1` loads first).

## Timing
- Trigger: a `trig_i` rising edge sampled at clock edge k gives `r1=1` after k; `cnt` updates at edge k+1.
- PPS: a `pps_i` rise sampled at edge k gives `pps_edge` during cycle k+1; `hold`, `dead_hold`, `seq` and `cnt` clear are visible after edge k+1.
- Gate: aligned with `r1`; `gate_i` and `trig_i` sampled high at the same edge means the edge is not counted.
- Readout: `scal_addr_i` presented before edge k gives `scal_dat_o` valid after edge k (1-cycle latency).
  - Hold values change only after a PPS edge.
  - Reads straddling a PPS edge may mix intervals; software reads using `seq`.
- Max counting rate: one edge per 2 clocks per channel (16.5 MHz).
- All outputs are 0 out of reset.

## Test plan
- Reset, then read every address → all 0 except `c3po_i` and `sec_i` passthrough (`seq=0`).
- 5 pulses on channel 3, 2 on channel 0, then PPS → addr 3 reads `0x00000005`, addr 0 reads `0x00000002`, addr `NUM_CHAN+2` low half = 1.
- `CNT_WIDTH=4`, 20 pulses on channel 1, then PPS → addr 1 reads `0x8000000F`; next interval with 3 pulses reads `0x00000003`.
- `gate_i` high for 100 cycles with 10 pulses inside and 4 outside, then PPS → channel count 4, addr `NUM_CHAN` reads 100.
- Trigger edge in the same cycle as `pps_edge` → excluded from the held value; next interval counts it (held 1 plus subsequent pulses).
- `rst_n_i` low for 1 cycle mid-interval after 7 pulses, then 2 pulses and PPS → reads 2, `seq=1`; 65536 PPS edges wrap `seq` to 0.
